// File: rtl/grid_sprite_move.sv
`default_nettype none
// ============================================================================
// Module   : grid_sprite_move
// Desc     : Tile-aligned sprite motion with buffered turns, stop-on-wall and a
//            once-per-frame position update. GRID_SPRITE_WRAP_EN selects tunnel
//            wrap of X instead of clamping.
// Revision : 1.0 - initial release
// ============================================================================
module grid_sprite_move #(
    parameter int INITIAL_X     = 288,
    parameter int INITIAL_Y     = 192,
    parameter int OBJECT_WIDTH  = 32,
    parameter int OBJECT_HEIGHT = 32,
    parameter int TILE_SIZE     = 16,
    parameter int SPEED         = 2,
    parameter int SCREEN_W      = 640,
    parameter int SCREEN_H      = 480
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               key_up,
    input  logic               key_down,
    input  logic               key_left,
    input  logic               key_right,
    input  logic               collision,
    input  logic [2:0]         HitEdgeCode,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic [1:0]         direction,
    output logic               moving
);

    typedef enum logic [2:0] {
        IDLE_ST    = 3'd0,
        COLLECT_ST = 3'd1,
        RESOLVE_ST = 3'd2,
        TURN_ST    = 3'd3,
        STEP_ST    = 3'd4,
        LIMIT_ST   = 3'd5
    } state_t;

    localparam logic [1:0] c_dir_up    = 2'd0;
    localparam logic [1:0] c_dir_down  = 2'd1;
    localparam logic [1:0] c_dir_left  = 2'd2;
    localparam logic [1:0] c_dir_right = 2'd3;

    localparam logic signed [11:0] c_speed  = 12'(SPEED);
    localparam logic signed [11:0] c_x_max  = 12'(SCREEN_W - OBJECT_WIDTH);
    localparam logic signed [11:0] c_y_max  = 12'(SCREEN_H - OBJECT_HEIGHT);
    localparam logic signed [11:0] c_init_x = 12'(INITIAL_X);
    localparam logic signed [11:0] c_init_y = 12'(INITIAL_Y);
    localparam logic [11:0]        c_tile_mask = 12'(TILE_SIZE - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic signed [11:0] r_x;
    logic signed [11:0] r_y;
    logic signed [11:0] r_cand_x;
    logic signed [11:0] r_cand_y;
    logic [1:0]         r_dir;
    logic               r_moving;
    logic [1:0]         r_pend_dir;
    logic               r_pend_valid;
    logic [4:0]         r_hit;

    logic               w_key_any;
    logic [1:0]         w_key_dir;
    logic [4:0]         w_hit_set;
    logic [4:0]         w_edge_mask;
    logic               w_hit_match;
    logic signed [11:0] w_dx;
    logic signed [11:0] w_dy;
    logic               w_aligned;
    logic               w_reverse;
    logic signed [11:0] w_lim_x;
    logic signed [11:0] w_lim_y;
    logic               w_lim_stop;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= IDLE_ST;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE_ST:    if (startOfFrame) w_next_state = COLLECT_ST;
            COLLECT_ST: if (startOfFrame) w_next_state = RESOLVE_ST;
            RESOLVE_ST: w_next_state = TURN_ST;
            TURN_ST:    w_next_state = STEP_ST;
            STEP_ST:    w_next_state = LIMIT_ST;
            LIMIT_ST:   w_next_state = COLLECT_ST;
            default:    w_next_state = IDLE_ST;
        endcase
    end

    // Key priority up > down > left > right
    always_comb begin
        w_key_any = key_up | key_down | key_left | key_right;
        w_key_dir = c_dir_right;
        if (key_up) begin
            w_key_dir = c_dir_up;
        end else if (key_down) begin
            w_key_dir = c_dir_down;
        end else if (key_left) begin
            w_key_dir = c_dir_left;
        end
    end

    // Edge codes above 4 shift out and are dropped
    assign w_hit_set = 5'b00001 << HitEdgeCode;

    always_comb begin
        w_dx        = 12'sd0;
        w_dy        = 12'sd0;
        w_edge_mask = 5'b00000;
        case (r_dir)
            c_dir_up:    begin w_dy = -c_speed; w_edge_mask = 5'b01000; end
            c_dir_down:  begin w_dy =  c_speed; w_edge_mask = 5'b00001; end
            c_dir_left:  begin w_dx = -c_speed; w_edge_mask = 5'b00010; end
            default:     begin w_dx =  c_speed; w_edge_mask = 5'b00100; end
        endcase
    end

    assign w_hit_match = |(r_hit & w_edge_mask);
    assign w_aligned   = ((r_x & c_tile_mask) == 12'd0) && ((r_y & c_tile_mask) == 12'd0);
    assign w_reverse   = (r_pend_dir == (r_dir ^ 2'b01));

    always_comb begin
        w_lim_y = r_cand_y;
        if (r_cand_y < 12'sd0) begin
            w_lim_y = 12'sd0;
        end else if (r_cand_y > c_y_max) begin
            w_lim_y = c_y_max;
        end
        w_lim_x    = r_cand_x;
        w_lim_stop = 1'b0;
`ifdef GRID_SPRITE_WRAP_EN
        if (r_cand_x < 12'sd0) begin
            w_lim_x = c_x_max;
        end else if (r_cand_x > c_x_max) begin
            w_lim_x = 12'sd0;
        end
`else
        if (r_cand_x <= 12'sd0) begin
            w_lim_x    = 12'sd0;
            w_lim_stop = (r_dir == c_dir_left);
        end else if (r_cand_x >= c_x_max) begin
            w_lim_x    = c_x_max;
            w_lim_stop = (r_dir == c_dir_right);
        end
`endif
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_x          <= c_init_x;
            r_y          <= c_init_y;
            r_cand_x     <= c_init_x;
            r_cand_y     <= c_init_y;
            r_dir        <= c_dir_right;
            r_moving     <= 1'b0;
            r_pend_dir   <= c_dir_right;
            r_pend_valid <= 1'b0;
            r_hit        <= 5'b00000;
        end else begin
            case (r_state)
                COLLECT_ST: begin
                    if (collision) begin
                        r_hit <= r_hit | w_hit_set;
                    end
                end
                RESOLVE_ST: begin
                    // Back off the step that put us into the wall
                    if (r_moving && w_hit_match) begin
                        r_moving <= 1'b0;
                        r_cand_x <= r_x - w_dx;
                        r_cand_y <= r_y - w_dy;
                    end else begin
                        r_cand_x <= r_x;
                        r_cand_y <= r_y;
                    end
                    r_hit <= 5'b00000;
                end
                TURN_ST: begin
                    if (r_pend_valid) begin
                        if (!r_moving) begin
                            r_dir        <= r_pend_dir;
                            r_moving     <= 1'b1;
                            r_pend_valid <= 1'b0;
                        end else if (r_pend_dir == r_dir) begin
                            r_pend_valid <= 1'b0;
                        end else if (w_reverse || w_aligned) begin
                            r_dir        <= r_pend_dir;
                            r_pend_valid <= 1'b0;
                        end
                    end
                end
                STEP_ST: begin
                    if (r_moving) begin
                        r_cand_x <= r_cand_x + w_dx;
                        r_cand_y <= r_cand_y + w_dy;
                    end
                end
                LIMIT_ST: begin
                    r_x <= w_lim_x;
                    r_y <= w_lim_y;
                    if (w_lim_stop) begin
                        r_moving <= 1'b0;
                    end
                end
                default: begin
                end
            endcase

            // A fresh key overrides any clear done above in the same cycle
            if (r_state != IDLE_ST && w_key_any) begin
                r_pend_dir   <= w_key_dir;
                r_pend_valid <= 1'b1;
            end
        end
    end

    assign topLeftX  = r_x[10:0];
    assign topLeftY  = r_y[10:0];
    assign direction = r_dir;
    assign moving    = r_moving;

endmodule
`default_nettype wire

// File: tb/tb_grid_sprite_move.sv
`default_nettype none
// ============================================================================
// Module   : tb_grid_sprite_move
// Desc     : Directed and randomized frames for grid_sprite_move, checked against
//            a per-frame behavioural model of the motion rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_grid_sprite_move;

    localparam int INIT_X = 288;
    localparam int INIT_Y = 192;
    localparam int OBJ_W  = 32;
    localparam int OBJ_H  = 32;
    localparam int TILE   = 16;
    localparam int SPD    = 2;
    localparam int SCR_W  = 640;
    localparam int SCR_H  = 480;

    localparam logic [3:0] K_UP    = 4'b0001;
    localparam logic [3:0] K_DOWN  = 4'b0010;
    localparam logic [3:0] K_LEFT  = 4'b0100;
    localparam logic [3:0] K_RIGHT = 4'b1000;

    logic               clk = 1'b0;
    logic               resetN;
    logic               startOfFrame;
    logic               key_up, key_down, key_left, key_right;
    logic               collision;
    logic [2:0]         HitEdgeCode;
    logic signed [10:0] topLeftX;
    logic signed [10:0] topLeftY;
    logic [1:0]         direction;
    logic               moving;

    always #5 clk = ~clk;

    grid_sprite_move #(
        .INITIAL_X(INIT_X), .INITIAL_Y(INIT_Y),
        .OBJECT_WIDTH(OBJ_W), .OBJECT_HEIGHT(OBJ_H),
        .TILE_SIZE(TILE), .SPEED(SPD),
        .SCREEN_W(SCR_W), .SCREEN_H(SCR_H)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .collision(collision), .HitEdgeCode(HitEdgeCode),
        .topLeftX(topLeftX), .topLeftY(topLeftY),
        .direction(direction), .moving(moving)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Headings: 0 up, 1 down, 2 left, 3 right
    int opp_tab[4]  = '{1, 0, 3, 2};
    int edge_tab[4] = '{3, 0, 1, 2};
    int dx_tab[4]   = '{0, 0, -SPD, SPD};
    int dy_tab[4]   = '{-SPD, SPD, 0, 0};

    int         m_x, m_y, m_dir, m_pd;
    bit         m_mov, m_pv;
    logic [4:0] m_hit;

    task automatic model_reset();
        m_x = INIT_X; m_y = INIT_Y; m_dir = 3; m_mov = 0;
        m_pv = 0; m_pd = 3; m_hit = '0;
    endtask

    task automatic model_key(input logic [3:0] keys);
        if (keys != 4'b0000) begin
            for (int i = 0; i < 4; i++) begin
                if (keys[i]) begin
                    m_pd = i;
                    break;
                end
            end
            m_pv = 1;
        end
    endtask

    task automatic model_frame();
        int bx, by;
        bx = m_x;
        by = m_y;
        if (m_mov && m_hit[edge_tab[m_dir]]) begin
            m_mov = 0;
            bx -= dx_tab[m_dir];
            by -= dy_tab[m_dir];
        end
        m_hit = '0;
        if (m_pv) begin
            if (!m_mov) begin
                m_dir = m_pd; m_mov = 1; m_pv = 0;
            end else if (m_pd == m_dir) begin
                m_pv = 0;
            end else if (m_pd == opp_tab[m_dir] || (m_x % TILE == 0 && m_y % TILE == 0)) begin
                m_dir = m_pd; m_pv = 0;
            end
        end
        if (m_mov) begin
            bx += dx_tab[m_dir];
            by += dy_tab[m_dir];
        end
        if (by < 0) by = 0;
        if (by > SCR_H - OBJ_H) by = SCR_H - OBJ_H;
`ifdef GRID_SPRITE_WRAP_EN
        if (bx < 0) bx = SCR_W - OBJ_W;
        else if (bx > SCR_W - OBJ_W) bx = 0;
`else
        if (bx <= 0) begin
            bx = 0;
            if (m_dir == 2) m_mov = 0;
        end else if (bx >= SCR_W - OBJ_W) begin
            bx = SCR_W - OBJ_W;
            if (m_dir == 3) m_mov = 0;
        end
`endif
        m_x = bx;
        m_y = by;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_x"}, int'(topLeftX), m_x);
        chk({tag, "_y"}, int'(topLeftY), m_y);
        chk({tag, "_dir"}, int'(direction), m_dir);
        chk({tag, "_mov"}, int'(moving), int'(m_mov));
    endtask

    task automatic set_keys(input logic [3:0] k);
        key_up = k[0]; key_down = k[1]; key_left = k[2]; key_right = k[3];
    endtask

    task automatic apply_reset();
        resetN = 1'b0;
        set_keys(4'b0000);
        startOfFrame = 1'b0;
        collision = 1'b0;
        HitEdgeCode = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
        model_reset();
    endtask

    task automatic leave_idle();
        startOfFrame = 1'b1;
        @(posedge clk); #1;
        startOfFrame = 1'b0;
        @(posedge clk); #1;
    endtask

    // Entered and left one time unit after a rising edge with the DUT collecting
    task automatic do_frame(input string tag, input logic [3:0] keys, input bit coll, input int code);
        if (coll) begin
            collision = 1'b1;
            HitEdgeCode = 3'(code);
            @(posedge clk); #1;
            collision = 1'b0;
            if (code <= 4) m_hit[code] = 1'b1;
        end
        if (keys != 4'b0000) begin
            set_keys(keys);
            @(posedge clk); #1;
            set_keys(4'b0000);
            model_key(keys);
        end
        startOfFrame = 1'b1;
        @(posedge clk); #1;
        startOfFrame = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        model_frame();
        check_all(tag);
    endtask

    initial begin
        logic [3:0] rk;
        bit         rc;

        resetN = 1'b0;
        apply_reset();
        check_all("reset");

        // Key during IDLE must be ignored
        set_keys(K_LEFT);
        @(posedge clk); #1;
        set_keys(4'b0000);
        leave_idle();
        check_all("idle_exit");
        do_frame("idle_key", 4'b0000, 0, 0);

        do_frame("r1", K_RIGHT, 0, 0);
        do_frame("r2", 4'b0000, 0, 0);
        do_frame("r3", 4'b0000, 0, 0);
        chk("tp_right_x", int'(topLeftX), 294);
        chk("tp_right_mov", int'(moving), 1);

        do_frame("up_req", K_UP, 0, 0);
        for (int i = 0; i < 4; i++) do_frame("up_wait", 4'b0000, 0, 0);
        chk("tp_hold_dir", int'(direction), 3);
        chk("tp_hold_x", int'(topLeftX), 304);
        do_frame("up_turn", 4'b0000, 0, 0);
        chk("tp_turn_dir", int'(direction), 0);
        chk("tp_turn_y", int'(topLeftY), 190);

        do_frame("reverse", K_DOWN, 0, 0);
        chk("tp_rev_dir", int'(direction), 1);
        do_frame("hit_bottom", 4'b0000, 1, 0);
        chk("tp_hit_mov", int'(moving), 0);
        chk("tp_hit_y", int'(topLeftY), 190);
        do_frame("stopped", 4'b0000, 0, 0);
        do_frame("resume", K_UP, 0, 0);
        do_frame("hit_top", 4'b0000, 1, 3);
        do_frame("prio", K_UP | K_LEFT, 0, 0);
        chk("tp_prio_dir", int'(direction), 0);
        do_frame("side_hit", 4'b0000, 1, 1);
        do_frame("corner_hit", 4'b0000, 1, 4);
        chk("tp_corner_mov", int'(moving), 1);

        // Key during TURN is deferred; an extra frame pulse mid-frame is dropped
        startOfFrame = 1'b1;
        @(posedge clk); #1;
        startOfFrame = 1'b0;
        @(posedge clk); #1;
        set_keys(K_DOWN);
        @(posedge clk); #1;
        set_keys(4'b0000);
        startOfFrame = 1'b1;
        @(posedge clk); #1;
        startOfFrame = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_frame();
        model_key(K_DOWN);
        check_all("late_key");
        do_frame("late_apply", 4'b0000, 0, 0);

        for (int i = 0; i < 150; i++) begin
            rk = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            rc = ($urandom_range(0, 3) == 0);
            do_frame("rand", rk, rc, int'($urandom_range(0, 4)));
        end

        apply_reset();
        leave_idle();
        do_frame("wall_go", K_LEFT, 0, 0);
        for (int i = 0; i < 200 && m_x != 0; i++) do_frame("wall_run", 4'b0000, 0, 0);
        chk("wall_reach_x", int'(topLeftX), 0);
        do_frame("wall_edge", 4'b0000, 0, 0);
`ifdef GRID_SPRITE_WRAP_EN
        chk("tp_wrap_x", int'(topLeftX), SCR_W - OBJ_W);
        chk("tp_wrap_mov", int'(moving), 1);
`else
        chk("tp_clamp_x", int'(topLeftX), 0);
        chk("tp_clamp_mov", int'(moving), 0);
`endif
        do_frame("pre_rst", K_RIGHT, 0, 0);

        startOfFrame = 1'b1;
        @(posedge clk); #1;
        startOfFrame = 1'b0;
        @(posedge clk); #1;
        resetN = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("tp_rst_x", int'(topLeftX), 288);
        chk("tp_rst_y", int'(topLeftY), 192);
        @(posedge clk); #1;
        resetN = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
